// File: rtl/mpsoc_ahb_pkg.sv
// Shared AHB-Lite encodings, the slave FSM state type and the write-lane helper.
package mpsoc_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  // Byte enables for a transfer of 2^size bytes starting at byte lane 'offset'.
  // Only meaningful for legal (aligned, size <= 3) transfers.
  function automatic logic [7:0] be_gen(input logic [2:0] size, input logic [2:0] offset);
    logic [3:0]  nbytes;
    logic [15:0] mask;
    nbytes = 4'd1 << size;
    mask   = (16'd1 << nbytes) - 16'd1;
    return mask[7:0] << offset;
  endfunction

endpackage

// File: rtl/mpsoc_ram_1rw.sv
// Byte-enabled RAM array with one write and one read port on a common clock.
// Read is synchronous with one cycle of latency and returns the pre-write
// contents when both ports hit the same word on the same edge.
module mpsoc_ram_1rw #(
  parameter int WORDS = 256,
  parameter int XLEN  = 32,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [XLEN/8-1:0] be,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [XLEN-1:0]   rdata
);

  // NOTE: the array has no reset; resetting it would block RAM inference.
  logic [XLEN-1:0] mem [WORDS];

  // Lane-masked write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < XLEN/8; i++) begin
      if (we && be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // Registered read; holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mpsoc_ahb_spram_ws.sv
// AHB-Lite on-chip RAM slave with programmable wait states, byte/halfword
// write lanes, write-to-read forwarding and two-cycle ERROR responses.
module mpsoc_ahb_spram_ws
  import mpsoc_ahb_pkg::*;
#(
  parameter int MEM_SIZE    = 1024,
  parameter int PLEN        = 32,
  parameter int XLEN        = 32,
  parameter int WAIT_STATES = 0,
  parameter int ERR_OOR     = 1
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int              BYTES     = XLEN / 8;
  localparam int              LANE_W    = $clog2(BYTES);
  localparam int              WORDS     = MEM_SIZE / BYTES;
  localparam int              IDX_W     = $clog2(WORDS);
  localparam logic [2:0]      MAX_SIZE  = 3'(LANE_W);
  localparam logic [PLEN-1:0] MEM_LIMIT = PLEN'(MEM_SIZE);

  state_t            state;
  logic [2:0]        wait_cnt;
  logic              hready_q, hresp_q;
  logic              dp_valid, dp_write;
  logic [IDX_W-1:0]  dp_idx;
  logic [BYTES-1:0]  dp_be;
  logic              fwd_valid;
  logic [BYTES-1:0]  fwd_be;
  logic [XLEN-1:0]   fwd_data;
  logic [XLEN-1:0]   hrdata_q, ram_q, merged;

  logic              take, req_err;
  logic [2:0]        align_mask;
  logic [7:0]        be_full;
  logic [BYTES-1:0]  req_be;
  logic [IDX_W-1:0]  req_idx;
  logic              complete, commit, rd_out;
  logic              unused;

  // Address-phase decode: only IDLE and ERR2 may take a new transfer.
  assign take       = HSEL && HREADY && HTRANS[1] && (state == IDLE || state == ERR2);
  assign align_mask = 3'((4'd1 << HSIZE) - 4'd1);
  assign req_err    = (HSIZE > MAX_SIZE) || ((HADDR[2:0] & align_mask) != 3'd0) ||
                      ((ERR_OOR != 0) && (HADDR >= MEM_LIMIT));
  assign be_full    = be_gen(HSIZE, 3'(HADDR[LANE_W-1:0]));
  assign req_be     = be_full[BYTES-1:0];
  assign req_idx    = HADDR[LANE_W +: IDX_W];

  // The final data-phase cycle is the one where a live transfer sits in IDLE.
  assign complete = dp_valid && (state == IDLE);
  assign commit   = complete && dp_write;
  assign rd_out   = complete && !dp_write;

  assign unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], be_full, HADDR};

  mpsoc_ram_1rw #(.WORDS(WORDS), .XLEN(XLEN), .AW(IDX_W)) u_ram (
    .clk   (HCLK),
    .we    (commit && !HRESET),
    .be    (dp_be),
    .waddr (dp_idx),
    .wdata (HWDATA),
    .re    (take && !req_err && !HWRITE && !HRESET),
    .raddr (req_idx),
    .rdata (ram_q)
  );

  // Overlay lanes written on the edge that accepted this read.
  always_comb begin
    // NOTE: default assignment first so every path drives merged (no latch).
    merged = ram_q;
    for (int i = 0; i < BYTES; i++) begin
      if (fwd_valid && fwd_be[i]) merged[i*8 +: 8] = fwd_data[i*8 +: 8];
    end
  end

  assign HRDATA    = rd_out ? merged : hrdata_q;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;

  // Transfer FSM with registered HREADYOUT/HRESP and data-phase bookkeeping.
  always_ff @(posedge HCLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (HRESET) begin
      state     <= IDLE;
      wait_cnt  <= 3'd0;
      hready_q  <= 1'b1;
      hresp_q   <= HRESP_OKAY;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_idx    <= '0;
      dp_be     <= '0;
      fwd_valid <= 1'b0;
      fwd_be    <= '0;
      fwd_data  <= '0;
      hrdata_q  <= '0;
    end else begin
      if (rd_out)   hrdata_q <= merged;
      if (complete) dp_valid <= 1'b0;
      case (state)
        IDLE, ERR2: begin
          state    <= IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          if (take) begin
            if (req_err) begin
              state    <= ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_ERROR;
            end else begin
              dp_valid  <= 1'b1;
              dp_write  <= HWRITE;
              dp_idx    <= req_idx;
              dp_be     <= req_be;
              fwd_valid <= !HWRITE && commit && (dp_idx == req_idx);
              fwd_be    <= dp_be;
              fwd_data  <= HWDATA;
              if (WAIT_STATES != 0) begin
                state    <= WAIT;
                hready_q <= 1'b0;
                wait_cnt <= 3'(WAIT_STATES);
              end
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd1) begin
            state    <= IDLE;
            hready_q <= 1'b1;
            wait_cnt <= 3'd0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ERR1: begin
          state    <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_ahb_spram_ws.sv
// Self-checking bench: a byte-array memory model plus per-cycle timing
// expectations, driving two slaves (0 and 3 wait states) through one master.
module tb_mpsoc_ahb_spram_ws;
  import mpsoc_ahb_pkg::*;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hsel, sel3, hwrite, hmastlock;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hready, ready0, ready3, resp0, resp3;
  logic [31:0] hrdata0, hrdata3, cur_rdata;
  logic        cur_resp;

  assign hready    = sel3 ? ready3 : ready0;
  assign cur_resp  = sel3 ? resp3 : resp0;
  assign cur_rdata = sel3 ? hrdata3 : hrdata0;

  mpsoc_ahb_spram_ws #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel && !sel3), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ready0), .HRESP(resp0)
  );

  mpsoc_ahb_spram_ws #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel && sel3), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(hrdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ready3), .HRESP(resp3)
  );

  int          errors = 0;
  int          checks = 0;
  xfer_t       q[$];
  logic [7:0]  mem_m [2][1024];
  logic [31:0] last_rd [2];
  logic [31:0] res_data [16];
  int          res_cyc [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input bit wr, input logic [31:0] a, input logic [2:0] s,
                               input logic [31:0] w, input logic [1:0] t);
    xfer_t x;
    x.wr = wr; x.addr = a; x.size = s; x.wdata = w; x.trans = t;
    return x;
  endfunction

  function automatic bit is_err(input xfer_t x);
    return (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0) || (x.addr >= 32'd1024);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {mem_m[d][b+3], mem_m[d][b+2], mem_m[d][b+1], mem_m[d][b]};
  endfunction

  task automatic model_write(input int d, input xfer_t x);
    int lane;
    for (int k = 0; k < (1 << x.size); k++) begin
      lane = (int'(x.addr) % 4) + k;
      mem_m[d][int'(x.addr) + k] = x.wdata[8*lane +: 8];
    end
  endtask

  // Pipelined master: issues queued transfers and checks every cycle against the model.
  task automatic run_seq(input bit use3);
    int ai, dp_idx, dp_cyc, n, guard, ws, d;
    bit have_dp, rdy, err, exp_rdy;
    logic [31:0] exp_rd;
    n = q.size(); ws = use3 ? 3 : 0; d = use3 ? 1 : 0;
    sel3 = use3; ai = 0; dp_idx = 0; dp_cyc = 0; guard = 0; have_dp = 1'b0;
    while ((ai < n || have_dp) && guard < 400) begin
      if (ai < n) begin
        hsel = 1'b1; htrans = q[ai].trans; haddr = q[ai].addr;
        hwrite = q[ai].wr; hsize = q[ai].size;
      end else begin
        hsel = 1'b0; htrans = HTRANS_IDLE;
      end
      if (have_dp) hwdata = q[dp_idx].wdata;
      #1;
      rdy = hready;
      if (have_dp) begin
        dp_cyc++;
        err = is_err(q[dp_idx]);
        exp_rdy = err ? (dp_cyc == 2) : (dp_cyc == ws + 1);
        check("hreadyout", 32'(rdy), 32'(exp_rdy));
        check("hresp", 32'(cur_resp), 32'(err));
        if (rdy) begin
          res_cyc[dp_idx] = dp_cyc;
          if (!err) begin
            if (q[dp_idx].wr) model_write(d, q[dp_idx]);
            else begin
              exp_rd = model_read(d, q[dp_idx].addr);
              check("hrdata", cur_rdata, exp_rd);
              res_data[dp_idx] = cur_rdata;
              last_rd[d] = exp_rd;
            end
          end
        end else if (dp_cyc > 8) begin
          check("data_phase_timeout", 32'(dp_cyc), 32'(ws + 1));
          break;
        end
      end else begin
        check("idle_hreadyout", 32'(rdy), 32'd1);
        check("idle_hresp", 32'(cur_resp), 32'd0);
        check("idle_hrdata_hold", cur_rdata, last_rd[d]);
      end
      @(posedge clk);
      if (rdy) begin
        have_dp = (ai < n);
        dp_idx  = ai;
        dp_cyc  = 0;
        if (ai < n) ai++;
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check("sequence_timeout", 32'(guard), 32'd0);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    q.delete();
  endtask

  initial begin
    int sum;
    rst = 1'b1; hsel = 1'b0; sel3 = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
    hsize = HSIZE_WORD; hburst = 3'd0; hprot = 4'd0; htrans = HTRANS_IDLE; hmastlock = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;

    // Reset held for two cycles.
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("rst_ready0", 32'(ready0), 32'd1);
      check("rst_resp0", 32'(resp0), 32'd0);
      check("rst_rdata0", hrdata0, 32'd0);
      check("rst_ready3", 32'(ready3), 32'd1);
      check("rst_resp3", 32'(resp3), 32'd0);
      check("rst_rdata3", hrdata3, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Zero wait states: word write/read, byte lane merge, forwarding, halfword.
    q.push_back(mk(1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, HTRANS_NONSEQ));
    q.push_back(mk(0, 32'h10, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ));
    q.push_back(mk(1, 32'h10, HSIZE_WORD, 32'h11223344, HTRANS_NONSEQ));
    q.push_back(mk(1, 32'h13, HSIZE_BYTE, 32'hAA000000, HTRANS_NONSEQ));
    q.push_back(mk(0, 32'h10, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ));
    q.push_back(mk(0, 32'h10, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ));
    q.push_back(mk(1, 32'h12, HSIZE_HALF, 32'h55660000, HTRANS_NONSEQ));
    q.push_back(mk(0, 32'h10, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ));
    run_seq(1'b0);
    check("lit_read_deadbeef", res_data[1], 32'hDEADBEEF);
    check("lit_forwarded_byte", res_data[4], 32'hAA223344);
    check("lit_stored_byte", res_data[5], 32'hAA223344);
    check("lit_halfword", res_data[7], 32'h55663344);

    // Error responses: out of range, misaligned halfword, oversize; RAM untouched.
    q.push_back(mk(1, 32'h000, HSIZE_WORD,  32'hCAFEF00D, HTRANS_NONSEQ));
    q.push_back(mk(1, 32'h400, HSIZE_WORD,  32'hFFFFFFFF, HTRANS_NONSEQ));
    q.push_back(mk(1, 32'h001, HSIZE_HALF,  32'hFFFFFFFF, HTRANS_NONSEQ));
    q.push_back(mk(1, 32'h008, HSIZE_DWORD, 32'hFFFFFFFF, HTRANS_NONSEQ));
    q.push_back(mk(0, 32'h000, HSIZE_WORD,  32'h0,        HTRANS_NONSEQ));
    run_seq(1'b0);
    check("lit_err_cycles", 32'(res_cyc[1]), 32'd2);
    check("lit_err_b2b_cycles", 32'(res_cyc[2]), 32'd2);
    check("lit_ram_unchanged", res_data[4], 32'hCAFEF00D);

    // Three wait states: burst writes, forwarded read, SEQ read burst, error.
    q.push_back(mk(1, 32'h40, HSIZE_WORD, 32'hA0000001, HTRANS_NONSEQ));
    q.push_back(mk(1, 32'h44, HSIZE_WORD, 32'hA0000002, HTRANS_SEQ));
    q.push_back(mk(1, 32'h48, HSIZE_WORD, 32'hA0000003, HTRANS_SEQ));
    q.push_back(mk(1, 32'h4C, HSIZE_WORD, 32'hA0000004, HTRANS_SEQ));
    q.push_back(mk(0, 32'h4C, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ));
    q.push_back(mk(0, 32'h40, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ));
    q.push_back(mk(0, 32'h44, HSIZE_WORD, 32'h0,        HTRANS_SEQ));
    q.push_back(mk(0, 32'h48, HSIZE_WORD, 32'h0,        HTRANS_SEQ));
    q.push_back(mk(0, 32'h4C, HSIZE_WORD, 32'h0,        HTRANS_SEQ));
    q.push_back(mk(1, 32'h404, HSIZE_WORD, 32'h0,       HTRANS_NONSEQ));
    q.push_back(mk(1, 32'h20, HSIZE_WORD, 32'h55555555, HTRANS_NONSEQ));
    run_seq(1'b1);
    check("lit_ws3_read_cycles", 32'(res_cyc[4]), 32'd4);
    check("lit_ws3_forward", res_data[4], 32'hA0000004);
    sum = res_cyc[5] + res_cyc[6] + res_cyc[7] + res_cyc[8];
    check("lit_seq_burst_cycles", 32'(sum), 32'd16);
    check("lit_burst_first", res_data[5], 32'hA0000001);
    check("lit_ws3_err_cycles", 32'(res_cyc[9]), 32'd2);

    // Reset in the middle of a write's wait states drops the write.
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge clk); @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h12345678;
    check("midwait_ready", 32'(ready3), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", 32'(ready3), 32'd1);
    check("post_rst_resp", 32'(resp3), 32'd0);
    check("post_rst_rdata", hrdata3, 32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    q.push_back(mk(0, 32'h20, HSIZE_WORD, 32'h0, HTRANS_NONSEQ));
    run_seq(1'b1);
    check("lit_write_dropped", res_data[0], 32'h55555555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
